gbdt_tree_walk_ctrl: RTL and testbench
======================================

Name: gbdt_tree_walk_ctrl

Overview:
- Sequences GBDT inference for one feature vector: walks each tree from root to leaf through the shared node memory and compares feature values against node thresholds.
- Hands each reached leaf to the leaf accumulator (enable/is_leaf/leaf_val/finish_condition/start_new_round).
- Sits between the host start/done interface, the node memory, the feature buffer and the accumulator.

Parameters:
- NODE_AW, 10, node memory address width.
- NUM_TREES_MAX, 64, maximum tree count; num_trees width is clog2(NUM_TREES_MAX+1).
- MAX_DEPTH, 15, node visits allowed per tree before abort.

Ports:
- gbdt_clk  in  1  clock
- gbdt_rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse; accepted only in IDLE
- num_trees  in  7  tree count, sampled on an accepted start; 0 is legal
- busy  out  1  high whenever state != IDLE
- done  out  1  single-cycle pulse at end of round
- err  out  1  sticky depth-overflow flag; cleared on an accepted start
- node_rd_en  out  1  node memory read strobe
- node_rd_addr  out  NODE_AW  read address
- node_rd_data  in  32  read data, valid exactly 1 cycle after node_rd_en
- feat_idx  out  6  feature buffer index
- feat_val  in  16  feature value, combinational from feat_idx
- acc_start_new_round  out  1  clears the accumulator
- acc_enable  out  1  accumulator update strobe
- acc_is_leaf  out  1  leaf marker
- acc_leaf_val  out  16  leaf value
- acc_finish  out  1  last-leaf marker
- acc_done  in  1  accumulator idle/done

Behaviour:
- Reset: state IDLE; all outputs 0, except node_rd_addr, feat_idx and acc_leaf_val, which are don't-care but driven 0. tree_idx, root, cur_addr and depth are cleared.
- Memory map: addresses 0..num_trees-1 are a root table; word[NODE_AW-1:0] is that tree's root address.
- Node word format:
  - [0] is_leaf
  - [6:1] feature index
  - [15:7] right-child offset (unsigned)
  - [31:16] threshold, or leaf value if is_leaf
- Child selection: left child = addr+1. Right child = addr + offset, computed modulo 2^NODE_AW (wraps).
- Comparison: unsigned. feat_val >= threshold selects right, otherwise left.
- FSM states:
  - IDLE: on start, latch num_trees, clear err, go to CLEAR. A start received in any other state is ignored.
  - CLEAR: acc_start_new_round=1 for 1 cycle, tree_idx=0. If num_trees==0, go to FIN. Otherwise go to ROOT_RD.
  - ROOT_RD: node_rd_en=1, addr=tree_idx, go to ROOT_WAIT.
  - ROOT_WAIT: cur_addr <= node_rd_data[NODE_AW-1:0], depth=0, go to NODE_RD.
  - NODE_RD: node_rd_en=1, addr=cur_addr, go to NODE_EVAL.
  - NODE_EVAL: feat_idx=node_rd_data[6:1], compare against threshold in the same cycle.
    - Leaf: acc_enable=1, acc_is_leaf=1, acc_leaf_val=data[31:16], acc_finish=(tree_idx==num_trees-1). If last tree go to WAIT_ACC; otherwise tree_idx++ and go to ROOT_RD.
    - Non-leaf with depth==MAX_DEPTH: set err, then emit acc_enable=1, acc_is_leaf=0, acc_leaf_val=0, acc_finish=1 (the accumulator latches its current sum), go to WAIT_ACC.
    - Non-leaf otherwise: cur_addr <= child, depth++, go to NODE_RD.
  - FIN (num_trees==0): acc_enable=1, acc_finish=1, acc_leaf_val=0, go to WAIT_ACC.
  - WAIT_ACC: wait for acc_done==1, then done=1 for 1 cycle and go to IDLE.
- Cycle costs:
  - start to acc_start_new_round: 1 cycle.
  - Per tree: 2 cycles for the root fetch plus 2 cycles per node visited (leaf included).
  - done follows the final acc_enable by 2 cycles, because acc_done rises 1 cycle after the final acc_enable.
- acc_* outputs are combinational from state and node_rd_data, so there are no bubbles.
- Exactly one acc_enable with acc_finish=1 occurs per round.
- Reset mid-walk: all state returns to IDLE asynchronously. No done pulse is produced.

Decomposition:
- Shared package gbdt_pkg holds:
  - node-word field constants: LEAF_BIT, FEAT_LSB/MSB, ROFF_LSB/MSB, VAL_LSB/MSB;
  - the walk_state_e enum;
  - node_addr_t.
- One natural sub-module, gbdt_node_decode: combinational. It unpacks the node word and computes next_addr from cur_addr, the offset and the compare result. It is reused by the verification model.

Test Plan:
- num_trees=1, root table[0]=8, node8 is a leaf with value 0x0042 -> acc_start_new_round at cycle 1; acc_enable with finish=1 and leaf_val=0x42 at cycle 5; done at cycle 7; accumulator result 0x42.
- num_trees=2, tree0 depth 2 (feat_val=100, threshold=100 -> right, leaf 5), tree1 left path (feat_val 3 < threshold 10 -> leaf 7) -> two acc_enable pulses, finish only on the second; result 12.
- num_trees=0 -> FIN path: acc_enable/finish with value 0, done pulse, result 0, err=0.
- Self-loop node (offset 0, non-leaf) with MAX_DEPTH=15 -> abort after 16 visits: err=1, done pulses, result holds the prior trees' sum.
- start pulsed while busy, then reset asserted mid-walk -> the second start is ignored; on reset busy=0, done never pulses, and outputs return to reset values.
- Right-child offset wraps (cur_addr=0x3FF, offset 2) -> next read address is 0x001.

Source files
------------

// File: rtl/gbdt_pkg.sv
// Shared definitions for the GBDT tree-walk controller: node word layout,
// walk FSM states and the default node address type.
package gbdt_pkg;

  localparam int unsigned LEAF_BIT = 0;
  localparam int unsigned FEAT_LSB = 1;
  localparam int unsigned FEAT_MSB = 6;
  localparam int unsigned ROFF_LSB = 7;
  localparam int unsigned ROFF_MSB = 15;
  localparam int unsigned VAL_LSB  = 16;
  localparam int unsigned VAL_MSB  = 31;

  localparam int unsigned NODE_AW_DEF = 10;

  typedef logic [NODE_AW_DEF-1:0] node_addr_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_ROOT_RD,
    ST_ROOT_WAIT,
    ST_NODE_RD,
    ST_NODE_EVAL,
    ST_FIN,
    ST_WAIT_ACC
  } walk_state_e;

endpackage

// File: rtl/gbdt_node_decode.sv
// Combinational node word unpacker: splits the fields and picks the next
// node address from an unsigned feature/threshold compare.
module gbdt_node_decode
  import gbdt_pkg::*;
#(
  parameter int unsigned NODE_AW = NODE_AW_DEF
) (
  input  logic [31:0]        node_word_i,
  input  logic [NODE_AW-1:0] cur_addr_i,
  input  logic [15:0]        feat_val_i,
  output logic               is_leaf_o,
  output logic [5:0]         feat_idx_o,
  output logic [15:0]        value_o,
  output logic [NODE_AW-1:0] next_addr_o
);

  logic [ROFF_MSB-ROFF_LSB:0] roff;
  logic                       go_right;

  // Kept as separate assigns so feat_idx_o does not appear to depend on
  // feat_val_i, which is fed back combinationally from outside.
  assign is_leaf_o   = node_word_i[LEAF_BIT];
  assign feat_idx_o  = node_word_i[FEAT_MSB:FEAT_LSB];
  assign value_o     = node_word_i[VAL_MSB:VAL_LSB];
  assign roff        = node_word_i[ROFF_MSB:ROFF_LSB];
  assign go_right    = (feat_val_i >= value_o);
  assign next_addr_o = go_right ? (cur_addr_i + NODE_AW'(roff))
                                : (cur_addr_i + NODE_AW'(1));

endmodule

// File: rtl/gbdt_tree_walk_ctrl.sv
// GBDT inference sequencer: walks each tree root-to-leaf through node memory
// and hands every reached leaf to the accumulator.
module gbdt_tree_walk_ctrl
  import gbdt_pkg::*;
#(
  parameter int unsigned NODE_AW       = 10,
  parameter int unsigned NUM_TREES_MAX = 64,
  parameter int unsigned MAX_DEPTH     = 15
) (
  input  logic                                 gbdt_clk,
  input  logic                                 gbdt_rst_n,
  input  logic                                 start,
  input  logic [$clog2(NUM_TREES_MAX+1)-1:0]   num_trees,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 err,
  output logic                                 node_rd_en,
  output logic [NODE_AW-1:0]                   node_rd_addr,
  input  logic [31:0]                          node_rd_data,
  output logic [5:0]                           feat_idx,
  input  logic [15:0]                          feat_val,
  output logic                                 acc_start_new_round,
  output logic                                 acc_enable,
  output logic                                 acc_is_leaf,
  output logic [15:0]                          acc_leaf_val,
  output logic                                 acc_finish,
  input  logic                                 acc_done
);

  localparam int unsigned TW = $clog2(NUM_TREES_MAX+1);
  localparam int unsigned DW = $clog2(MAX_DEPTH+1);

  walk_state_e        state_q, state_d;
  logic [TW-1:0]      num_trees_q, num_trees_d;
  logic [TW-1:0]      tree_idx_q, tree_idx_d;
  logic [NODE_AW-1:0] cur_addr_q, cur_addr_d;
  logic [DW-1:0]      depth_q, depth_d;
  logic               err_q, err_d;
  logic               done_q, done_d;

  logic               dec_is_leaf;
  logic [5:0]         dec_feat_idx;
  logic [15:0]        dec_value;
  logic [NODE_AW-1:0] dec_next_addr;
  logic               last_tree;

  gbdt_node_decode #(.NODE_AW(NODE_AW)) u_decode (
    .node_word_i (node_rd_data),
    .cur_addr_i  (cur_addr_q),
    .feat_val_i  (feat_val),
    .is_leaf_o   (dec_is_leaf),
    .feat_idx_o  (dec_feat_idx),
    .value_o     (dec_value),
    .next_addr_o (dec_next_addr)
  );

  assign last_tree = (tree_idx_q == (num_trees_q - TW'(1)));
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign feat_idx  = (state_q == ST_NODE_EVAL) ? dec_feat_idx : '0;

  always_ff @(posedge gbdt_clk or negedge gbdt_rst_n) begin
    if (!gbdt_rst_n) begin
      state_q     <= ST_IDLE;
      num_trees_q <= '0;
      tree_idx_q  <= '0;
      cur_addr_q  <= '0;
      depth_q     <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_trees_q <= num_trees_d;
      tree_idx_q  <= tree_idx_d;
      cur_addr_q  <= cur_addr_d;
      depth_q     <= depth_d;
      err_q       <= err_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d             = state_q;
    num_trees_d         = num_trees_q;
    tree_idx_d          = tree_idx_q;
    cur_addr_d          = cur_addr_q;
    depth_d             = depth_q;
    err_d               = err_q;
    done_d              = 1'b0;
    node_rd_en          = 1'b0;
    node_rd_addr        = '0;
    acc_start_new_round = 1'b0;
    acc_enable          = 1'b0;
    acc_is_leaf         = 1'b0;
    acc_leaf_val        = '0;
    acc_finish          = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          num_trees_d = num_trees;
          err_d       = 1'b0;
          state_d     = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        acc_start_new_round = 1'b1;
        tree_idx_d          = '0;
        state_d             = (num_trees_q == '0) ? ST_FIN : ST_ROOT_RD;
      end
      ST_ROOT_RD: begin
        node_rd_en   = 1'b1;
        node_rd_addr = NODE_AW'(tree_idx_q);
        state_d      = ST_ROOT_WAIT;
      end
      ST_ROOT_WAIT: begin
        cur_addr_d = node_rd_data[NODE_AW-1:0];
        depth_d    = '0;
        state_d    = ST_NODE_RD;
      end
      ST_NODE_RD: begin
        node_rd_en   = 1'b1;
        node_rd_addr = cur_addr_q;
        state_d      = ST_NODE_EVAL;
      end
      ST_NODE_EVAL: begin
        if (dec_is_leaf) begin
          acc_enable   = 1'b1;
          acc_is_leaf  = 1'b1;
          acc_leaf_val = dec_value;
          acc_finish   = last_tree;
          if (last_tree) begin
            state_d = ST_WAIT_ACC;
          end else begin
            tree_idx_d = tree_idx_q + TW'(1);
            state_d    = ST_ROOT_RD;
          end
        end else if (depth_q == DW'(MAX_DEPTH)) begin
          // Depth overflow ends the round; the accumulator keeps its sum.
          err_d      = 1'b1;
          acc_enable = 1'b1;
          acc_finish = 1'b1;
          state_d    = ST_WAIT_ACC;
        end else begin
          cur_addr_d = dec_next_addr;
          depth_d    = depth_q + DW'(1);
          state_d    = ST_NODE_RD;
        end
      end
      ST_FIN: begin
        acc_enable = 1'b1;
        acc_finish = 1'b1;
        state_d    = ST_WAIT_ACC;
      end
      ST_WAIT_ACC: begin
        if (acc_done) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_gbdt_tree_walk_ctrl.sv
// Directed and randomized bench for gbdt_tree_walk_ctrl against a
// tree-walking reference model over the bench's own node memory.
module tb_gbdt_tree_walk_ctrl;
  import gbdt_pkg::*;

  localparam int MAXD = 15;

  logic        gbdt_clk = 1'b0;
  logic        gbdt_rst_n;
  logic        start;
  logic [6:0]  num_trees;
  logic        busy, done, err;
  logic        node_rd_en;
  node_addr_t  node_rd_addr;
  logic [31:0] node_rd_data = '0;
  logic [5:0]  feat_idx;
  logic [15:0] feat_val;
  logic        acc_start_new_round, acc_enable, acc_is_leaf, acc_finish;
  logic [15:0] acc_leaf_val;
  logic        acc_done = 1'b0;

  gbdt_tree_walk_ctrl #(.NODE_AW(10), .NUM_TREES_MAX(64), .MAX_DEPTH(MAXD)) dut (
    .gbdt_clk(gbdt_clk), .gbdt_rst_n(gbdt_rst_n), .start(start), .num_trees(num_trees),
    .busy(busy), .done(done), .err(err), .node_rd_en(node_rd_en),
    .node_rd_addr(node_rd_addr), .node_rd_data(node_rd_data), .feat_idx(feat_idx),
    .feat_val(feat_val), .acc_start_new_round(acc_start_new_round),
    .acc_enable(acc_enable), .acc_is_leaf(acc_is_leaf), .acc_leaf_val(acc_leaf_val),
    .acc_finish(acc_finish), .acc_done(acc_done)
  );

  always #5 gbdt_clk = ~gbdt_clk;

  logic [31:0] mem  [0:1023];
  logic [15:0] feat [0:63];

  always @(posedge gbdt_clk) if (node_rd_en) node_rd_data <= mem[node_rd_addr];
  assign feat_val = feat[feat_idx];

  // Accumulator: sums leaves, latches result and pulses acc_done after finish.
  logic [31:0] acc_sum = '0, acc_result = '0;
  always @(posedge gbdt_clk) begin
    acc_done <= 1'b0;
    if (acc_start_new_round) acc_sum <= '0;
    if (acc_enable && acc_is_leaf) acc_sum <= acc_sum + 32'(acc_leaf_val);
    if (acc_enable && acc_finish) begin
      acc_result <= acc_sum + (acc_is_leaf ? 32'(acc_leaf_val) : 32'd0);
      acc_done   <= 1'b1;
    end
  end

  longint t0 = 0;
  int ev_cyc[$], ev_val[$], ev_leaf[$], ev_fin[$], rdq[$], nrq[$], doneq[$];

  function automatic int cyc_now();
    return int'((longint'($time) - t0 + 5) / 10);
  endfunction

  always @(negedge gbdt_clk) begin
    if (acc_enable) begin
      ev_cyc.push_back(cyc_now());
      ev_val.push_back(int'(acc_leaf_val));
      ev_leaf.push_back(int'(acc_is_leaf));
      ev_fin.push_back(int'(acc_finish));
    end
    if (node_rd_en) rdq.push_back(int'(node_rd_addr));
    if (acc_start_new_round) nrq.push_back(cyc_now());
    if (done) doneq.push_back(cyc_now());
  end

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] node(input int leaf, input int f, input int off, input int v);
    return {v[15:0], off[8:0], f[5:0], leaf[0]};
  endfunction

  // Reference: walk trees directly over mem/feat, counting cycles per visit.
  int exp_sum, exp_en, exp_last, exp_last_val, exp_last_leaf, exp_err;
  int exp_rd[$];

  task automatic model_round(input int nt);
    logic [31:0] w;
    int addr, cyc;
    bit aborted;
    exp_rd.delete();
    exp_sum = 0; exp_en = 0; exp_err = 0; exp_last_val = 0; exp_last_leaf = 0;
    cyc = 1; aborted = 0;
    if (nt == 0) begin
      exp_en = 1; cyc = 2;
    end
    for (int t = 0; t < nt && !aborted; t++) begin
      exp_rd.push_back(t);
      w = mem[t]; addr = int'(w[9:0]); cyc += 2;
      for (int v = 0; v <= MAXD; v++) begin
        exp_rd.push_back(addr);
        w = mem[addr]; cyc += 2;
        if (w[0]) begin
          exp_sum += int'(w[31:16]); exp_en++;
          exp_last_val = int'(w[31:16]); exp_last_leaf = 1;
          break;
        end
        if (v == MAXD) begin
          exp_err = 1; exp_en++; aborted = 1;
          exp_last_val = 0; exp_last_leaf = 0;
          break;
        end
        if (feat[w[6:1]] >= w[31:16]) addr = (addr + int'(w[15:7])) % 1024;
        else addr = (addr + 1) % 1024;
      end
    end
    exp_last = cyc;
  endtask

  task automatic clear_logs();
    ev_cyc.delete(); ev_val.delete(); ev_leaf.delete(); ev_fin.delete();
    rdq.delete(); nrq.delete(); doneq.delete();
  endtask

  task automatic pulse_start(input int nt, input bit set_t0);
    @(negedge gbdt_clk);
    num_trees = 7'(nt);
    start = 1'b1;
    @(posedge gbdt_clk);
    if (set_t0) t0 = longint'($time);
    #1 start = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_rd_en"}, 32'(node_rd_en), 0);
    chk({tag, "_rd_addr"}, 32'(node_rd_addr), 0);
    chk({tag, "_feat_idx"}, 32'(feat_idx), 0);
    chk({tag, "_new_round"}, 32'(acc_start_new_round), 0);
    chk({tag, "_acc_en"}, 32'(acc_enable), 0);
    chk({tag, "_acc_leaf"}, 32'(acc_is_leaf), 0);
    chk({tag, "_acc_val"}, 32'(acc_leaf_val), 0);
    chk({tag, "_acc_fin"}, 32'(acc_finish), 0);
  endtask

  int last_cyc, done_cyc;

  task automatic run_round(input int nt, input string tag);
    int n, mism, fins, lval, lleaf;
    model_round(nt);
    clear_logs();
    pulse_start(nt, 1'b1);
    n = 0;
    while (doneq.size() == 0 && n < 5000) begin
      @(negedge gbdt_clk);
      n++;
    end
    repeat (3) @(negedge gbdt_clk);
    chk({tag, "_done_cnt"}, doneq.size(), 1);
    chk({tag, "_newround_cnt"}, nrq.size(), 1);
    chk({tag, "_newround_cyc"}, (nrq.size() > 0) ? nrq[0] : -1, 1);
    chk({tag, "_en_cnt"}, ev_cyc.size(), exp_en);
    fins = 0;
    foreach (ev_fin[i]) fins += ev_fin[i];
    chk({tag, "_fin_cnt"}, fins, 1);
    last_cyc = (ev_cyc.size() > 0) ? ev_cyc[ev_cyc.size()-1] : -1;
    lval     = (ev_val.size() > 0) ? ev_val[ev_val.size()-1] : -1;
    lleaf    = (ev_leaf.size() > 0) ? ev_leaf[ev_leaf.size()-1] : -1;
    done_cyc = (doneq.size() > 0) ? doneq[0] : -1;
    chk({tag, "_last_fin"}, (ev_fin.size() > 0) ? ev_fin[ev_fin.size()-1] : -1, 1);
    chk({tag, "_last_val"}, lval, exp_last_val);
    chk({tag, "_last_leaf"}, lleaf, exp_last_leaf);
    chk({tag, "_last_en_cyc"}, last_cyc, exp_last);
    chk({tag, "_done_cyc"}, done_cyc, exp_last + 2);
    chk({tag, "_result"}, acc_result, exp_sum);
    chk({tag, "_err"}, 32'(err), exp_err);
    chk({tag, "_busy_after"}, 32'(busy), 0);
    mism = 0;
    foreach (exp_rd[i]) if (i >= rdq.size() || rdq[i] != exp_rd[i]) mism++;
    chk({tag, "_rd_cnt"}, rdq.size(), exp_rd.size());
    chk({tag, "_rd_mism"}, mism, 0);
  endtask

  initial begin
    int nt;
    gbdt_rst_n = 1'b0; start = 1'b0; num_trees = '0;
    for (int a = 0; a < 1024; a++) mem[a] = '0;
    for (int f = 0; f < 64; f++) feat[f] = '0;
    #1 chk_idle("reset");
    repeat (2) @(negedge gbdt_clk);
    gbdt_rst_n = 1'b1;

    // Single tree whose root is a leaf.
    mem[0] = 32'd8;
    mem[8] = node(1, 0, 0, 16'h0042);
    run_round(1, "t1");
    chk("t1_en_cyc_abs", last_cyc, 5);
    chk("t1_done_cyc_abs", done_cyc, 7);
    chk("t1_result_abs", acc_result, 32'h42);

    // Two trees: equality goes right, smaller goes left.
    mem[0] = 32'd20; mem[1] = 32'd40;
    mem[20] = node(0, 3, 5, 100); mem[25] = node(1, 0, 0, 5);
    mem[40] = node(0, 4, 7, 10);  mem[41] = node(1, 0, 0, 7);
    feat[3] = 16'd100; feat[4] = 16'd3;
    run_round(2, "t2");
    chk("t2_result_abs", acc_result, 12);

    // Second tree loops on itself until the depth limit aborts it.
    mem[0] = 32'd50; mem[1] = 32'd60;
    mem[50] = node(1, 0, 0, 9);
    mem[60] = node(0, 0, 0, 0);
    run_round(2, "loop");
    chk("loop_err_abs", 32'(err), 1);
    chk("loop_result_abs", acc_result, 9);

    // Zero trees also clears the sticky error.
    run_round(0, "zero");
    chk("zero_result_abs", acc_result, 0);

    // Right-child offset wraps past the top of the address space.
    mem[0] = 32'h3FF;
    mem[1023] = node(0, 0, 2, 0);
    mem[1] = node(1, 0, 0, 16'h77);
    run_round(1, "wrap");
    chk("wrap_addr", (rdq.size() > 2) ? rdq[2] : -1, 1);

    // Restart while busy is ignored; reset mid-walk aborts without done.
    mem[0] = 32'd200;
    mem[200] = node(0, 0, 0, 0);
    clear_logs();
    pulse_start(1, 1'b1);
    repeat (4) @(negedge gbdt_clk);
    pulse_start(5, 1'b0);
    repeat (3) @(negedge gbdt_clk);
    chk("mid_busy", 32'(busy), 1);
    chk("mid_newround_cnt", nrq.size(), 1);
    gbdt_rst_n = 1'b0;
    #1 chk_idle("midrst");
    clear_logs();
    repeat (3) @(negedge gbdt_clk);
    gbdt_rst_n = 1'b1;
    repeat (40) @(negedge gbdt_clk);
    chk("midrst_no_done", doneq.size(), 0);
    chk("midrst_no_acc", ev_cyc.size(), 0);
    chk("midrst_busy", 32'(busy), 0);

    // Recovery after reset.
    mem[0] = 32'd8;
    run_round(1, "recover");

    // Randomized trees and features.
    for (int r = 0; r < 20; r++) begin
      for (int a = 0; a < 64; a++) mem[a] = 32'($urandom_range(64, 1023));
      for (int a = 64; a < 1024; a++) begin
        mem[a] = $urandom;
        mem[a][0] = ($urandom_range(0, 2) == 0);
      end
      for (int f = 0; f < 64; f++) feat[f] = 16'($urandom);
      nt = (r == 19) ? 64 : int'($urandom_range(0, 10));
      run_round(nt, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
